// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe board access path.
//   cellStateType : encoding of one board cell (EMPTY/X/O; 01 reads as EMPTY)
//   arbStateType  : states of the board access arbiter
//   LINES         : cell indices of the 3 rows, 3 columns and 2 diagonals
//   isX / isO     : cell decoders, anything that is not X or O counts as EMPTY
package tictactoe_pkg;

    localparam int NCELLS = 9;
    localparam int AW     = 4;
    localparam int CW     = 2;
    localparam int NLINES = 8;

    typedef enum logic [CW-1:0] {
        EMPTY = 2'b00,
        X     = 2'b10,
        O     = 2'b11
    } cellStateType;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        EVAL  = 3'd4
    } arbStateType;

    localparam logic [0:NLINES-1][0:2][AW-1:0] LINES = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic isX(input logic [CW-1:0] c);
        return (c == X);
    endfunction

    function automatic logic isO(input logic [CW-1:0] c);
        return (c == O);
    endfunction

endpackage

// File: rtl/line_checker.sv
// Combinational evaluation of a 3x3 board.
//   board  : NCELLS cells, cell 0 in the low slice
//   winner : X if any X line exists (X wins an illegal double win), else O, else EMPTY
//   draw   : no winner and every cell holds X or O
module line_checker
    import tictactoe_pkg::*;
(
    input  logic [NCELLS-1:0][CW-1:0] board,
    output logic [CW-1:0]             winner,
    output logic                      draw
);

    logic xLine;
    logic oLine;
    logic full;

    always_comb begin
        xLine  = 1'b0;
        oLine  = 1'b0;
        full   = 1'b1;
        winner = EMPTY;
        for (int l = 0; l < NLINES; l++) begin
            xLine = xLine | (isX(board[LINES[l][0]]) & isX(board[LINES[l][1]]) & isX(board[LINES[l][2]]));
            oLine = oLine | (isO(board[LINES[l][0]]) & isO(board[LINES[l][1]]) & isO(board[LINES[l][2]]));
        end
        for (int c = 0; c < NCELLS; c++) begin
            full = full & (isX(board[c]) | isO(board[c]));
        end
        if (xLine) begin
            winner = X;
        end else if (oLine) begin
            winner = O;
        end
        draw = ~xLine & ~oLine & full;
    end

endmodule

// File: rtl/board_access_arbiter.sv
// Owns the single board RAM port. Grants cell writes from the game controller,
// and after every write (or on scanReq) reads cells 0..NCELLS-1 into a shadow
// board, evaluates it and publishes winner/draw/gameIsDone.
//   ph1, reset_n          : clock, asynchronous active-low reset
//   wrReq/wrAddr/wrData   : write request, answered by a wrGnt or wrErr pulse
//   scanReq, newGame      : rescan pulse, result clear pulse
//   memAddr/memWe/memWdata: registered RAM controls; memRdata is one cycle late
//   busy, scanDone        : not-IDLE flag, results-updated pulse
//   winner/draw/gameIsDone: registered game result
//   dbgState              : current arbiter state for observation
module board_access_arbiter
    import tictactoe_pkg::*;
(
    input  logic              ph1,
    input  logic              reset_n,
    input  logic              wrReq,
    input  logic [AW-1:0]     wrAddr,
    input  logic [CW-1:0]     wrData,
    output logic              wrGnt,
    output logic              wrErr,
    input  logic              scanReq,
    input  logic              newGame,
    output logic [AW-1:0]     memAddr,
    output logic              memWe,
    output logic [CW-1:0]     memWdata,
    input  logic [CW-1:0]     memRdata,
    output logic              busy,
    output logic              scanDone,
    output logic [CW-1:0]     winner,
    output logic              draw,
    output logic              gameIsDone,
    output arbStateType       dbgState
);

    arbStateType              state;
    logic [NCELLS-1:0][CW-1:0] shadow;
    logic                     capEn;    // memRdata this cycle belongs to capAddr
    logic [AW-1:0]            capAddr;
    logic [CW-1:0]            lcWinner;
    logic                     lcDraw;

    line_checker uLineChecker (
        .board  (shadow),
        .winner (lcWinner),
        .draw   (lcDraw)
    );

    assign busy     = (state != IDLE);
    assign dbgState = state;

    // Write handshake: the requester holds wrReq (with stable wrAddr/wrData)
    // until it sees exactly one of wrGnt or wrErr for one cycle, then drops it.
    // While wrErr is high the request is already answered, so a still-held
    // wrReq in that cycle is not evaluated again.
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            memAddr    <= '0;
            memWe      <= 1'b0;
            memWdata   <= '0;
            wrGnt      <= 1'b0;
            wrErr      <= 1'b0;
            scanDone   <= 1'b0;
            winner     <= '0;
            draw       <= 1'b0;
            gameIsDone <= 1'b0;
            capEn      <= 1'b0;
            capAddr    <= '0;
            shadow     <= '0;
        end else begin
            wrGnt    <= 1'b0;
            wrErr    <= 1'b0;
            scanDone <= 1'b0;
            memWe    <= 1'b0;
            capEn    <= 1'b0;

            if (capEn) begin
                shadow[capAddr] <= memRdata;
            end

            // EVAL below is later in the block, so a scan finishing in the
            // same cycle as newGame keeps its fresh result.
            if (newGame) begin
                winner     <= '0;
                draw       <= 1'b0;
                gameIsDone <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (wrReq) begin
                        if (!wrErr) begin
                            if ((wrAddr >= AW'(NCELLS)) || gameIsDone) begin
                                wrErr <= 1'b1;
                            end else begin
                                state    <= WRITE;
                                memWe    <= 1'b1;
                                memAddr  <= wrAddr;
                                memWdata <= wrData;
                                wrGnt    <= 1'b1;
                            end
                        end
                    end else if (scanReq) begin
                        state   <= READ;
                        memAddr <= '0;
                    end
                end
                WRITE: begin
                    state   <= READ;
                    memAddr <= '0;
                end
                READ: begin
                    capEn   <= 1'b1;
                    capAddr <= memAddr;
                    if (memAddr == AW'(NCELLS - 1)) begin
                        state <= DRAIN;
                    end else begin
                        memAddr <= memAddr + AW'(1);
                    end
                end
                DRAIN: begin
                    state <= EVAL;
                end
                EVAL: begin
                    winner     <= lcWinner;
                    draw       <= lcDraw;
                    gameIsDone <= (lcWinner != EMPTY) | lcDraw;
                    scanDone   <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_access_arbiter.sv
// Directed bench for board_access_arbiter with a behavioural board RAM.
module tb_board_access_arbiter;
    import tictactoe_pkg::*;

    logic          ph1 = 1'b0;
    logic          reset_n = 1'b0;
    logic          wrReq = 1'b0;
    logic [3:0]    wrAddr = '0;
    logic [1:0]    wrData = '0;
    logic          scanReq = 1'b0;
    logic          newGame = 1'b0;
    logic [1:0]    memRdata = '0;
    logic          wrGnt, wrErr, memWe, busy, scanDone, draw, gameIsDone;
    logic [3:0]    memAddr;
    logic [1:0]    memWdata, winner;
    arbStateType   dbgState;

    int checks = 0;
    int failures = 0;

    logic [1:0] ram [16] = '{default: 2'b00};

    board_access_arbiter dut (
        .ph1(ph1), .reset_n(reset_n), .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData),
        .wrGnt(wrGnt), .wrErr(wrErr), .scanReq(scanReq), .newGame(newGame),
        .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata), .memRdata(memRdata),
        .busy(busy), .scanDone(scanDone), .winner(winner), .draw(draw),
        .gameIsDone(gameIsDone), .dbgState(dbgState)
    );

    // clock / RAM model
    always #5 ph1 = ~ph1;

    always @(posedge ph1) begin
        if (memWe) ram[memAddr] <= memWdata;
        memRdata <= ram[memAddr];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    // Driver: request a write, wait (bounded) for the grant, then count cycles to scanDone.
    task automatic drive_write(input logic [3:0] a, input logic [1:0] d, output int gntWait, output int doneWait);
        wrAddr = a; wrData = d; wrReq = 1'b1;
        gntWait = -1; doneWait = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (wrGnt === 1'b1) begin gntWait = i; break; end
        end
        wrReq = 1'b0;
        if (gntWait < 0) return;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (scanDone === 1'b1) begin doneWait = i; break; end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({wrGnt, wrErr, memWe, busy, scanDone, draw, gameIsDone, memAddr, memWdata, winner} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b err=%b we=%b busy=%b done=%b draw=%b gid=%b addr=%0d wd=%b win=%b, expected all 0",
                     wrGnt, wrErr, memWe, busy, scanDone, draw, gameIsDone, memAddr, memWdata, winner);
        end
        tick();
        checks++;
        if (dbgState !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbgState, IDLE); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_first_write();
        wrAddr = 4'd4; wrData = 2'b10; wrReq = 1'b1;
        tick();
        wrReq = 1'b0;
        checks++;
        if ({wrGnt, memWe, memAddr, memWdata, busy} !== {1'b1, 1'b1, 4'd4, 2'b10, 1'b1}) begin
            failures++;
            $display("FAIL first_write_grant: got gnt=%b we=%b addr=%0d wd=%b busy=%b, expected gnt=1 we=1 addr=4 wd=10 busy=1",
                     wrGnt, memWe, memAddr, memWdata, busy);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if ({memWe, memAddr} !== {1'b0, 4'(i)}) begin
                failures++;
                $display("FAIL first_write_walk: got we=%b addr=%0d, expected we=0 addr=%0d", memWe, memAddr, i);
            end
        end
        tick(); tick();
        checks++;
        if (scanDone !== 1'b0 || dbgState !== EVAL) begin
            failures++;
            $display("FAIL first_write_eval: got done=%b state=%0d, expected done=0 state=%0d", scanDone, dbgState, EVAL);
        end
        tick();
        checks++;
        if ({scanDone, busy, winner, draw, gameIsDone} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL first_write_done: got done=%b busy=%b win=%b draw=%b gid=%b, expected 1 0 00 0 0",
                     scanDone, busy, winner, draw, gameIsDone);
        end
        checks++;
        if (ram[4] !== 2'b10) begin failures++; $display("FAIL first_write_ram: got %b expected 10", ram[4]); end
    endtask

    task automatic test_busy_write();
        int doneAt;
        logic sawGnt;
        int g, dn;
        doneAt = -1; sawGnt = 1'b0;
        scanReq = 1'b1;
        tick();
        scanReq = 1'b0;
        checks++;
        if (busy !== 1'b1 || memAddr !== 4'd0 || dbgState !== READ) begin
            failures++;
            $display("FAIL busy_write_scan_start: got busy=%b addr=%0d state=%0d, expected busy=1 addr=0 state=%0d", busy, memAddr, dbgState, READ);
        end
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin wrAddr = 4'd0; wrData = 2'b11; wrReq = 1'b1; end
            tick();
            if (wrGnt === 1'b1) sawGnt = 1'b1;
            if (scanDone === 1'b1) begin doneAt = k; break; end
        end
        checks++;
        if (doneAt != 11 || sawGnt !== 1'b0) begin
            failures++;
            $display("FAIL busy_write_scan_latency: got done_after=%0d early_gnt=%b, expected 11 and 0", doneAt, sawGnt);
        end
        tick();
        checks++;
        if ({wrGnt, memWe, memAddr, memWdata} !== {1'b1, 1'b1, 4'd0, 2'b11}) begin
            failures++;
            $display("FAIL busy_write_grant: got gnt=%b we=%b addr=%0d wd=%b, expected 1 1 0 11", wrGnt, memWe, memAddr, memWdata);
        end
        wrReq = 1'b0;
        g = -1; dn = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (scanDone === 1'b1) begin dn = k; break; end
        end
        checks++;
        if (dn != 12 || winner !== 2'b00 || ram[0] !== 2'b11) begin
            failures++;
            $display("FAIL busy_write_done: got latency=%0d win=%b ram0=%b, expected 12 00 11", dn, winner, ram[0]);
        end
    endtask

    task automatic test_x_win();
        logic [3:0] addrs [5] = '{4'd0, 4'd3, 4'd1, 4'd5, 4'd2};
        logic [1:0] datas [5] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
        int g, dn;
        for (int i = 0; i < 5; i++) begin
            drive_write(addrs[i], datas[i], g, dn);
            checks++;
            if (g != 1 || dn != 12) begin
                failures++;
                $display("FAIL x_win_latency: write %0d got gnt_wait=%0d done_wait=%0d, expected 1 and 12", i, g, dn);
            end
            if (i < 4) begin
                checks++;
                if (winner !== 2'b00 || gameIsDone !== 1'b0) begin
                    failures++;
                    $display("FAIL x_win_early: write %0d got win=%b gid=%b, expected 00 0", i, winner, gameIsDone);
                end
            end
        end
        checks++;
        if ({winner, draw, gameIsDone} !== {2'b10, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL x_win_result: got win=%b draw=%b gid=%b, expected 10 0 1", winner, draw, gameIsDone);
        end
        wrAddr = 4'd6; wrData = 2'b11; wrReq = 1'b1;
        tick();
        checks++;
        if ({wrErr, wrGnt, memWe, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL x_win_reject: got err=%b gnt=%b we=%b busy=%b, expected 1 0 0 0", wrErr, wrGnt, memWe, busy);
        end
        tick();
        wrReq = 1'b0;
        checks++;
        if ({wrErr, wrGnt, memWe} !== 3'b000 || ram[6] !== 2'b00) begin
            failures++;
            $display("FAIL x_win_reject_pulse: got err=%b gnt=%b we=%b ram6=%b, expected 0 0 0 00", wrErr, wrGnt, memWe, ram[6]);
        end
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
        checks++;
        if ({winner, draw, gameIsDone} !== 4'b0000) begin
            failures++;
            $display("FAIL x_win_newgame: got win=%b draw=%b gid=%b, expected 00 0 0", winner, draw, gameIsDone);
        end
    endtask

    task automatic test_draw();
        logic [3:0] addrs [6] = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8};
        logic [1:0] datas [6] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10};
        int g, dn;
        for (int i = 0; i < 6; i++) begin
            drive_write(addrs[i], datas[i], g, dn);
            checks++;
            if (g != 1 || dn != 12 || winner !== 2'b00) begin
                failures++;
                $display("FAIL draw_write: write %0d got gnt_wait=%0d done_wait=%0d win=%b, expected 1 12 00", i, g, dn, winner);
            end
        end
        checks++;
        if ({winner, draw, gameIsDone} !== {2'b00, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL draw_result: got win=%b draw=%b gid=%b, expected 00 1 1", winner, draw, gameIsDone);
        end
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
        checks++;
        if ({winner, draw, gameIsDone} !== 4'b0000) begin
            failures++;
            $display("FAIL draw_newgame: got win=%b draw=%b gid=%b, expected 00 0 0", winner, draw, gameIsDone);
        end
    endtask

    task automatic test_bad_addr();
        logic [3:0] bad [2] = '{4'd9, 4'd15};
        logic sawWe;
        for (int i = 0; i < 2; i++) begin
            sawWe = 1'b0;
            wrAddr = bad[i]; wrData = 2'b10; wrReq = 1'b1;
            tick();
            wrReq = 1'b0;
            checks++;
            if (wrErr !== 1'b1 || wrGnt !== 1'b0 || dbgState !== IDLE) begin
                failures++;
                $display("FAIL bad_addr_err: addr %0d got err=%b gnt=%b state=%0d, expected 1 0 %0d", bad[i], wrErr, wrGnt, dbgState, IDLE);
            end
            for (int k = 0; k < 5; k++) begin
                if (memWe === 1'b1 || busy === 1'b1) sawWe = 1'b1;
                tick();
            end
            checks++;
            if (sawWe !== 1'b0 || wrErr !== 1'b0) begin
                failures++;
                $display("FAIL bad_addr_quiet: addr %0d got we_or_busy_seen=%b err=%b, expected 0 0", bad[i], sawWe, wrErr);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g, dn;
        drive_write(4'd8, 2'b11, g, dn);
        checks++;
        if (g != 1 || dn != 12 || {winner, draw, gameIsDone} !== {2'b00, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_setup: got gnt_wait=%0d done_wait=%0d win=%b draw=%b gid=%b, expected 1 12 00 1 1",
                     g, dn, winner, draw, gameIsDone);
        end
        scanReq = 1'b1;
        tick();
        scanReq = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL reset_mid_busy: got %b expected 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({wrGnt, wrErr, memWe, busy, scanDone, draw, gameIsDone, memAddr, memWdata, winner} !== 17'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got we=%b busy=%b done=%b draw=%b gid=%b addr=%0d win=%b, expected all 0",
                     memWe, busy, scanDone, draw, gameIsDone, memAddr, winner);
        end
        #2;
        reset_n = 1'b1;
        tick();
        checks++;
        if (ram[8] !== 2'b11) begin failures++; $display("FAIL reset_mid_ram: got %b expected 11", ram[8]); end
        scanReq = 1'b1;
        tick();
        scanReq = 1'b0;
        checks++;
        if (memAddr !== 4'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_rescan_start: got addr=%0d busy=%b, expected 0 1", memAddr, busy);
        end
        dn = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (scanDone === 1'b1) begin dn = k; break; end
        end
        checks++;
        if (dn != 11 || {winner, draw, gameIsDone} !== {2'b00, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_rescan: got latency=%0d win=%b draw=%b gid=%b, expected 11 00 1 1", dn, winner, draw, gameIsDone);
        end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_busy_write();
        test_x_win();
        test_draw();
        test_bad_addr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
